// File: rtl/irq_priority_encoder_pkg.sv
// irq_priority_encoder_pkg: shared constants and FSM state encoding for the interrupt priority encoder
package irq_priority_encoder_pkg;
    localparam int N_REQ = 8;
    localparam int VW    = 3;
    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;
endpackage

// File: rtl/irq_priority_encoder_prio_enc_8x3.sv
// prio_enc_8x3: combinational highest-set-bit encoder
//   in  [7:0]  bit vector to search
//   out [2:0]  index of the highest set bit (0 when none)
//   any        1 when at least one bit of in is set
module prio_enc_8x3
    import irq_priority_encoder_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [VW-1:0]    out,
    output logic             any
);
    always_comb begin
        out = '0;
        for (int i = 0; i < N_REQ; i++)
            if (in[i]) out = VW'(i);
    end
    assign any = |in;
endmodule

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: 8-line edge-capturing interrupt priority encoder with irq/ack/eoi handshake and nesting
//   clk, rst_n  clock and asynchronous active-low reset
//   E           global enable; gates presentation only
//   REQ [7:0]   edge-sensitive request lines, REQ[7] highest priority
//   MASK [7:0]  1 = line masked (pending still recorded)
//   ACK, EOI    CPU accept / end-of-interrupt pulses
//   IRQ         registered interrupt request
//   V [2:0]     registered vector, valid while IRQ=1
//   ISR [7:0]   registered in-service bits
module irq_priority_encoder
    import irq_priority_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E,
    input  logic [N_REQ-1:0] REQ,
    input  logic [N_REQ-1:0] MASK,
    input  logic             ACK,
    input  logic             EOI,
    output logic             IRQ,
    output logic [VW-1:0]    V,
    output logic [N_REQ-1:0] ISR
);
    state_t           state_q, state_d;
    logic [N_REQ-1:0] req_q, pend_q, pend_d, isr_q, isr_d;
    logic [N_REQ-1:0] rise, elig, cand, clr, v_hot, isr_hot;
    logic [VW-1:0]    v_q, v_d, cand_v, isr_hi;
    logic             armed_q, cand_any, isr_any, keep, accept;

    prio_enc_8x3 u_cand (.in(cand),  .out(cand_v), .any(cand_any));
    prio_enc_8x3 u_isr  (.in(isr_q), .out(isr_hi), .any(isr_any));

    always_comb begin
        // req_q holds 0 through reset; armed_q suppresses the first post-reset
        // sample so a line already high at release is not seen as a new edge
        rise    = REQ & ~req_q & {N_REQ{armed_q}};
        // only indices strictly above the highest in-service line may interrupt
        elig    = isr_any ? N_REQ'(9'h1FE << isr_hi) : '1;
        cand    = pend_q & ~MASK & elig;
        v_hot   = N_REQ'(1) << v_q;
        isr_hot = N_REQ'(1) << isr_hi;
        keep    = E & cand[v_q];
        // withdrawal beats ACK: an ACK only counts while the vector is still valid
        accept  = (state_q == ASSERT) & keep & ACK;
        clr     = accept ? v_hot : '0;
        pend_d  = (pend_q & ~clr) | rise;
        isr_d   = (isr_q & ~((EOI & isr_any) ? isr_hot : '0)) | clr;
        state_d = (state_q == IDLE) ? ((E & cand_any) ? ASSERT : IDLE)
                                    : ((keep & ~ACK) ? ASSERT : IDLE);
        v_d     = (state_q == IDLE && E && cand_any) ? cand_v : v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            v_q     <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= REQ;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            v_q     <= v_d;
            armed_q <= 1'b1;
        end
    end

    assign IRQ = (state_q == ASSERT);
    assign V   = v_q;
    assign ISR = isr_q;
endmodule
